// File: rtl/sma_ch_sched_if.sv
// Channel request and result handshake bundle for sma_ch_sched.
interface sma_ch_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 16
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH*DW-1:0] ch_x;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 y_valid;
    logic                 y_ready;
    logic signed [DW-1:0] y;
    logic [CW-1:0]        y_ch;

    modport master (
        output ch_valid, ch_x, y_ready,
        input  ch_ready, y_valid, y, y_ch
    );

    modport slave (
        input  ch_valid, ch_x, y_ready,
        output ch_ready, y_valid, y, y_ch
    );
endinterface

// File: rtl/sma_ch_sched.sv
// Time-shared 4-tap moving average over NUM_CH channels with round-robin grant
// and a single-entry output register.
//
// state | meaning
// EMPTY | no result held, y_valid=0
// FULL  | result held on y/y_ch, y_valid=1
module sma_ch_sched #(
    parameter int NUM_CH = 4,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    sma_ch_sched_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = DW + 2;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]           state;
    logic [CW-1:0]        last;
    logic signed [DW-1:0] xp1 [NUM_CH];
    logic signed [DW-1:0] xp2 [NUM_CH];
    logic signed [DW-1:0] xp3 [NUM_CH];
    logic signed [DW-1:0] xp4 [NUM_CH];
    logic signed [AW-1:0] acc [NUM_CH];
    logic signed [DW-1:0] y_q;
    logic [CW-1:0]        y_ch_q;

    logic                 cap;
    logic                 found;
    logic [CW-1:0]        gidx;
    logic [NUM_CH-1:0]    gnt;
    logic                 accept;
    logic signed [DW-1:0] x_sel;
    logic signed [AW-1:0] acc_new;
    logic signed [AW-1:0] acc_bias;
    logic signed [AW-1:0] q;
    logic signed [DW-1:0] y_next;
    logic                 q_unused;

    assign cap = !clr && ((state == EMPTY) || bus.y_ready);

    // Search starts one past the last grant; offset NUM_CH wraps back to last itself.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && bus.ch_valid[last + CW'(i)]) begin
                found = 1'b1;
                gidx  = last + CW'(i);
            end
        end
    end

    // rst gates the grant directly so nothing is offered while reset is held.
    assign gnt          = (rst && cap && found) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gidx) : '0;
    assign bus.ch_ready = gnt;
    assign accept       = |(bus.ch_valid & gnt);

    assign x_sel    = bus.ch_x[gidx*DW +: DW];
    assign acc_new  = acc[gidx] - {{2{xp4[gidx][DW-1]}}, xp4[gidx]} + {{2{x_sel[DW-1]}}, x_sel};
    // Bias negatives by 3 before the arithmetic shift to truncate toward zero.
    assign acc_bias = acc_new + (acc_new[AW-1] ? AW'(3) : AW'(0));
    assign q        = acc_bias >>> 2;
    assign y_next   = {q[AW-1], q[DW-2:0]};
    assign q_unused = ^q[DW:DW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            last   <= CW'(NUM_CH - 1);
            y_q    <= '0;
            y_ch_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                xp1[i] <= '0;
                xp2[i] <= '0;
                xp3[i] <= '0;
                xp4[i] <= '0;
                acc[i] <= '0;
            end
        end else if (clr) begin
            state  <= EMPTY;
            last   <= CW'(NUM_CH - 1);
            y_q    <= '0;
            y_ch_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                xp1[i] <= '0;
                xp2[i] <= '0;
                xp3[i] <= '0;
                xp4[i] <= '0;
                acc[i] <= '0;
            end
        end else if (accept) begin
            state     <= FULL;
            last      <= gidx;
            y_q       <= y_next;
            y_ch_q    <= gidx;
            xp4[gidx] <= xp3[gidx];
            xp3[gidx] <= xp2[gidx];
            xp2[gidx] <= xp1[gidx];
            xp1[gidx] <= x_sel;
            acc[gidx] <= acc_new;
        end else if (state == FULL && bus.y_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.y_valid = (state == FULL);
    assign bus.y       = y_q;
    assign bus.y_ch    = y_ch_q;
endmodule

// File: tb/tb_sma_ch_sched.sv
// Scoreboard bench for sma_ch_sched: reference model of windowed averages and
// round-robin grant, directed scenarios followed by randomized traffic.
module tb_sma_ch_sched;
    localparam int NUM_CH = 4;
    localparam int DW     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    sma_ch_sched_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

    sma_ch_sched #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave)
    );

    typedef struct {
        int ch;
        int y;
    } res_t;

    int   errors = 0;
    int   checks = 0;
    res_t sbq[$];
    int   hist[NUM_CH][4];
    int   last;
    bit   full;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 4; k++)
                hist[c][k] = 0;
        last = NUM_CH - 1;
        full = 1'b0;
        sbq.delete();
    endtask

    function automatic int exp_grant(input logic [NUM_CH-1:0] v, input logic yr, input logic c);
        if (c || (full && !yr)) return -1;
        for (int off = 1; off <= NUM_CH; off++) begin
            if (v[(last + off) % NUM_CH]) return (last + off) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH*DW-1:0] mk(input int ch, input int x);
        logic [NUM_CH*DW-1:0] r;
        r = '0;
        r[ch*DW +: DW] = DW'(x);
        return r;
    endfunction

    // One clock of stimulus: drive after negedge, check grant, then advance the model.
    task automatic cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DW-1:0] xs,
                         input logic yr, input logic c, output int g);
        logic [NUM_CH-1:0] expr;
        int s;
        @(negedge clk);
        bus.ch_valid = v;
        bus.ch_x     = xs;
        bus.y_ready  = yr;
        clr          = c;
        #1;
        g    = exp_grant(v, yr, c);
        expr = (g >= 0) ? (NUM_CH'(1) << g) : '0;
        check("ch_ready", int'(bus.ch_ready), int'(expr));
        check("y_valid", int'(bus.y_valid), int'(full));
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (g >= 0) begin
            for (int k = 3; k > 0; k--) hist[g][k] = hist[g][k-1];
            hist[g][0] = int'($signed(xs[g*DW +: DW]));
            s = hist[g][0] + hist[g][1] + hist[g][2] + hist[g][3];
            sbq.push_back('{g, s / 4});
            full = 1'b1;
            last = g;
        end else if (full && yr) begin
            full = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        res_t e;
        if (rst && bus.y_valid && bus.y_ready && !clr) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got y=%0d ch=%0d, expected no result", bus.y, bus.y_ch);
            end else begin
                e = sbq.pop_front();
                check("y", int'(bus.y), e.y);
                check("y_ch", int'(bus.y_ch), e.ch);
            end
        end
    end

    initial begin
        int g;
        int y0, c0;
        logic [NUM_CH*DW-1:0] rx;
        bit pend[NUM_CH];
        logic [DW-1:0] px[NUM_CH];
        logic [NUM_CH-1:0] v;
        logic [NUM_CH*DW-1:0] xs;
        logic yr, c;

        bus.ch_valid = '1;
        bus.ch_x     = '0;
        bus.y_ready  = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #3;
        check("rst_y_valid", int'(bus.y_valid), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_y_ch", int'(bus.y_ch), 0);
        check("rst_ch_ready", int'(bus.ch_ready), 0);
        bus.ch_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // Single channel ramp-up
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0001, mk(0, 100), 1'b1, 1'b0, g);
            #1;
            check("ramp_y", int'(bus.y), 25 * (i + 1));
            check("ramp_ch", int'(bus.y_ch), 0);
        end
        cycle('0, '0, 1'b1, 1'b0, g);

        // Truncation toward zero
        cycle(4'b0010, mk(1, -4), 1'b1, 1'b0, g);
        #1 check("trunc_m4", int'(bus.y), -1);
        cycle('0, '0, 1'b1, 1'b1, g);
        cycle(4'b0010, mk(1, -3), 1'b1, 1'b0, g);
        #1 check("trunc_m3", int'(bus.y), 0);
        cycle('0, '0, 1'b1, 1'b0, g);

        // Round-robin order with all channels requesting
        cycle('0, '0, 1'b1, 1'b1, g);
        for (int i = 0; i < 6; i++) begin
            rx = (NUM_CH*DW)'({$urandom(), $urandom()});
            cycle(4'b1111, rx, 1'b1, 1'b0, g);
            #1 check("rr_ch", int'(bus.y_ch), i % NUM_CH);
        end
        cycle('0, '0, 1'b1, 1'b0, g);

        // Backpressure hold, then handshake plus acceptance
        cycle(4'b0100, mk(2, 40), 1'b1, 1'b0, g);
        #1;
        y0 = int'(bus.y);
        c0 = int'(bus.y_ch);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, mk(3, 77), 1'b0, 1'b0, g);
            #1;
            check("hold_y", int'(bus.y), y0);
            check("hold_ch", int'(bus.y_ch), c0);
        end
        cycle(4'b1111, mk(3, 77), 1'b1, 1'b0, g);
        #1;
        check("hs_valid", int'(bus.y_valid), 1);
        check("hs_new_ch", int'(bus.y_ch), 3);
        cycle('0, '0, 1'b1, 1'b0, g);

        // Interleaved channels, no contamination
        cycle('0, '0, 1'b1, 1'b1, g);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0001, mk(0, 400), 1'b1, 1'b0, g);
            #1 check("ilv_ch0", int'(bus.y), 100 * (i + 1));
            cycle(4'b0100, mk(2, -400), 1'b1, 1'b0, g);
            #1 check("ilv_ch2", int'(bus.y), -100 * (i + 1));
        end
        cycle('0, '0, 1'b1, 1'b0, g);

        // Reset pulse while a result is held
        cycle(4'b0010, mk(1, 1000), 1'b0, 1'b0, g);
        @(negedge clk);
        bus.ch_valid = '1;
        #2 rst = 1'b0;
        #1;
        check("rstp_y_valid", int'(bus.y_valid), 0);
        check("rstp_ch_ready", int'(bus.ch_ready), 0);
        model_reset();
        bus.ch_valid = '0;
        bus.y_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle(4'b1000, mk(3, 8), 1'b1, 1'b0, g);
        #1;
        check("rstp_y", int'(bus.y), 2);
        check("rstp_ch", int'(bus.y_ch), 3);
        cycle('0, '0, 1'b1, 1'b0, g);

        // Randomized traffic; a pending request is held until granted
        for (int c2 = 0; c2 < NUM_CH; c2++) begin
            pend[c2] = 1'b0;
            px[c2]   = '0;
        end
        for (int n = 0; n < 1500; n++) begin
            v  = '0;
            xs = '0;
            for (int c2 = 0; c2 < NUM_CH; c2++) begin
                if (!pend[c2] && $urandom_range(0, 2) == 0) begin
                    pend[c2] = 1'b1;
                    px[c2]   = DW'($urandom());
                end
                v[c2] = pend[c2];
                xs[c2*DW +: DW] = px[c2];
            end
            yr = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 199) == 0);
            cycle(v, xs, yr, c, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        for (int n = 0; n < 3; n++) cycle('0, '0, 1'b1, 1'b0, g);
        check("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
